// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the two-master AXI4 burst arbiter.
package axi_arb_pkg;

    // Number of requesting masters sharing the slave port.
    localparam int C_REQ_NUM = 2;

    // Width the ID helper works on; narrower IDs are zero-extended by the caller.
    localparam int C_ID_MAX = 32;

    // Grant FSM states shared by the AW and AR arbiters.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Requester index carried in bit 0 of a slave-side ID.
    function automatic logic id_req_idx(input logic [C_ID_MAX-1:0] id);
        logic unused_hi_s;
        unused_hi_s = ^id[C_ID_MAX-1:1];
        return id[0];
    endfunction

endpackage

// File: rtl/axi_arb_rr2.sv
// Two-way round-robin, burst-granular address-channel grant FSM.
// A grant is registered in IDLE and held in GRANT until the downstream
// handshake, after which the other requester gets priority.
module axi_arb_rr2
    import axi_arb_pkg::*;
(
    input  logic                 axi_clk,
    input  logic                 axi_reset,
    input  logic [C_REQ_NUM-1:0] req,
    input  logic                 allow,
    input  logic                 m_ready,
    output logic                 m_valid,
    output logic                 grant,
    output logic [C_REQ_NUM-1:0] s_ready
);

    arb_state_e state_r;
    arb_state_e state_nxt_s;
    logic       grant_r;
    logic       grant_nxt_s;
    logic       rr_r;
    logic       rr_nxt_s;

    // State, registered grant and round-robin pointer.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state_r <= IDLE;
            grant_r <= 1'b0;
            rr_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            rr_r    <= rr_nxt_s;
        end
    end

    // Next-state: pick a requester in IDLE, release after the handshake.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        rr_nxt_s    = rr_r;
        case (state_r)
            IDLE: begin
                if ((req != 2'b00) && allow) begin
                    state_nxt_s = GRANT;
                    if (req == 2'b11) begin
                        grant_nxt_s = rr_r;
                    end else begin
                        grant_nxt_s = req[1];
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (m_ready) begin
                    state_nxt_s = IDLE;
                    rr_nxt_s    = ~grant_r;
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign m_valid = (state_r == GRANT);
    assign grant   = grant_r;

    // Ready is passed through only to the granted requester.
    always_comb begin
        s_ready = 2'b00;
        if (state_r == GRANT) begin
            s_ready[grant_r] = m_ready;
        end else begin
            s_ready = 2'b00;
        end
    end

endmodule

// File: rtl/axi4_burst_arbiter.sv
// Shares one AXI4 slave port between two frame-buffer masters.
// AW/AR are arbitrated round-robin per burst; W follows AW order through a
// small write-order FIFO; B and R are steered back by ID bit 0.
module axi4_burst_arbiter
    import axi_arb_pkg::*;
#(
    parameter int C_ID_LEN   = 8,
    parameter int C_DATA_LEN = 128,
    parameter int C_STRB_LEN = C_DATA_LEN / 8,
    parameter int C_WR_OUT   = 4
) (
    input  logic                          axi_clk,
    input  logic                          axi_reset,
    // requester 0
    input  logic [31:0]                   s0_awaddr,
    input  logic [7:0]                    s0_awlen,
    input  logic                          s0_awvalid,
    output logic                          s0_awready,
    input  logic [C_DATA_LEN-1:0]         s0_wdata,
    input  logic [C_STRB_LEN-1:0]         s0_wstrb,
    input  logic                          s0_wlast,
    input  logic                          s0_wvalid,
    output logic                          s0_wready,
    output logic [1:0]                    s0_bresp,
    output logic                          s0_bvalid,
    input  logic [31:0]                   s0_araddr,
    input  logic [7:0]                    s0_arlen,
    input  logic                          s0_arvalid,
    output logic                          s0_arready,
    output logic [C_DATA_LEN-1:0]         s0_rdata,
    output logic [1:0]                    s0_rresp,
    output logic                          s0_rlast,
    output logic                          s0_rvalid,
    input  logic                          s0_rready,
    // requester 1
    input  logic [31:0]                   s1_awaddr,
    input  logic [7:0]                    s1_awlen,
    input  logic                          s1_awvalid,
    output logic                          s1_awready,
    input  logic [C_DATA_LEN-1:0]         s1_wdata,
    input  logic [C_STRB_LEN-1:0]         s1_wstrb,
    input  logic                          s1_wlast,
    input  logic                          s1_wvalid,
    output logic                          s1_wready,
    output logic [1:0]                    s1_bresp,
    output logic                          s1_bvalid,
    input  logic [31:0]                   s1_araddr,
    input  logic [7:0]                    s1_arlen,
    input  logic                          s1_arvalid,
    output logic                          s1_arready,
    output logic [C_DATA_LEN-1:0]         s1_rdata,
    output logic [1:0]                    s1_rresp,
    output logic                          s1_rlast,
    output logic                          s1_rvalid,
    input  logic                          s1_rready,
    // DDR slave port
    output logic [C_ID_LEN-1:0]           m_awid,
    output logic [31:0]                   m_awaddr,
    output logic [7:0]                    m_awlen,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [C_DATA_LEN-1:0]         m_wdata,
    output logic [C_STRB_LEN-1:0]         m_wstrb,
    output logic                          m_wlast,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic [C_ID_LEN-1:0]           m_bid,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    output logic [C_ID_LEN-1:0]           m_arid,
    output logic [31:0]                   m_araddr,
    output logic [7:0]                    m_arlen,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [C_ID_LEN-1:0]           m_rid,
    input  logic [C_DATA_LEN-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    // debug
    output logic [$clog2(C_WR_OUT):0]     wr_out_cnt
);

    localparam int C_PTR_LEN = $clog2(C_WR_OUT);
    localparam int C_CNT_LEN = C_PTR_LEN + 1;

    logic                 aw_valid_s;
    logic                 aw_grant_s;
    logic [C_REQ_NUM-1:0] aw_ready_s;
    logic                 ar_valid_s;
    logic                 ar_grant_s;
    logic [C_REQ_NUM-1:0] ar_ready_s;

    logic                 fifo_mem_r [C_WR_OUT];
    logic [C_PTR_LEN-1:0] wr_ptr_r;
    logic [C_PTR_LEN-1:0] rd_ptr_r;
    logic [C_CNT_LEN-1:0] cnt_r;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 head_s;
    logic                 b_idx_s;
    logic                 r_idx_s;

    axi_arb_rr2 u_aw_arb (
        .axi_clk   (axi_clk),
        .axi_reset (axi_reset),
        .req       ({s1_awvalid, s0_awvalid}),
        .allow     (~fifo_full_s),
        .m_ready   (m_awready),
        .m_valid   (aw_valid_s),
        .grant     (aw_grant_s),
        .s_ready   (aw_ready_s)
    );

    axi_arb_rr2 u_ar_arb (
        .axi_clk   (axi_clk),
        .axi_reset (axi_reset),
        .req       ({s1_arvalid, s0_arvalid}),
        .allow     (1'b1),
        .m_ready   (m_arready),
        .m_valid   (ar_valid_s),
        .grant     (ar_grant_s),
        .s_ready   (ar_ready_s)
    );

    // AW channel: mux the granted requester onto the DDR port.
    always_comb begin
        m_awvalid  = aw_valid_s;
        m_awid     = {{(C_ID_LEN-1){1'b0}}, aw_grant_s};
        s0_awready = aw_ready_s[0];
        s1_awready = aw_ready_s[1];
        if (aw_grant_s) begin
            m_awaddr = s1_awaddr;
            m_awlen  = s1_awlen;
        end else begin
            m_awaddr = s0_awaddr;
            m_awlen  = s0_awlen;
        end
    end

    // AR channel: same muxing with its own grant.
    always_comb begin
        m_arvalid  = ar_valid_s;
        m_arid     = {{(C_ID_LEN-1){1'b0}}, ar_grant_s};
        s0_arready = ar_ready_s[0];
        s1_arready = ar_ready_s[1];
        if (ar_grant_s) begin
            m_araddr = s1_araddr;
            m_arlen  = s1_arlen;
        end else begin
            m_araddr = s0_araddr;
            m_arlen  = s0_arlen;
        end
    end

    assign fifo_full_s  = (cnt_r == C_CNT_LEN'(C_WR_OUT));
    assign fifo_empty_s = (cnt_r == {C_CNT_LEN{1'b0}});
    assign push_s       = aw_valid_s & m_awready;
    assign pop_s        = m_wvalid & m_wready & m_wlast;
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign wr_out_cnt   = cnt_r;

    // Write-order FIFO: one entry per accepted AW, retired on the last W beat.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            wr_ptr_r <= {C_PTR_LEN{1'b0}};
            rd_ptr_r <= {C_PTR_LEN{1'b0}};
            cnt_r    <= {C_CNT_LEN{1'b0}};
            for (int i = 0; i < C_WR_OUT; i++) begin
                fifo_mem_r[i] <= 1'b0;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= aw_grant_s;
                wr_ptr_r             <= wr_ptr_r + C_PTR_LEN'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + C_PTR_LEN'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + C_CNT_LEN'(1'b1);
                2'b01:   cnt_r <= cnt_r - C_CNT_LEN'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // W channel: follow the FIFO head; nothing flows while it is empty.
    always_comb begin
        m_wdata   = s0_wdata;
        m_wstrb   = s0_wstrb;
        m_wlast   = s0_wlast;
        m_wvalid  = 1'b0;
        s0_wready = 1'b0;
        s1_wready = 1'b0;
        if (!fifo_empty_s) begin
            if (head_s) begin
                m_wdata   = s1_wdata;
                m_wstrb   = s1_wstrb;
                m_wlast   = s1_wlast;
                m_wvalid  = s1_wvalid;
                s1_wready = m_wready;
            end else begin
                m_wvalid  = s0_wvalid;
                s0_wready = m_wready;
            end
        end else begin
            m_wvalid = 1'b0;
        end
    end

    assign b_idx_s = id_req_idx(C_ID_MAX'(m_bid));
    assign r_idx_s = id_req_idx(C_ID_MAX'(m_rid));

    // B channel: steer the response to the requester named by bid[0].
    always_comb begin
        m_bready  = 1'b1;
        s0_bresp  = m_bresp;
        s1_bresp  = m_bresp;
        if (b_idx_s) begin
            s0_bvalid = 1'b0;
            s1_bvalid = m_bvalid;
        end else begin
            s0_bvalid = m_bvalid;
            s1_bvalid = 1'b0;
        end
    end

    // R channel: per-beat steering by rid[0], so interleaved returns are fine.
    always_comb begin
        s0_rdata = m_rdata;
        s1_rdata = m_rdata;
        s0_rresp = m_rresp;
        s1_rresp = m_rresp;
        s0_rlast = m_rlast;
        s1_rlast = m_rlast;
        if (r_idx_s) begin
            s0_rvalid = 1'b0;
            s1_rvalid = m_rvalid;
            m_rready  = s1_rready;
        end else begin
            s0_rvalid = m_rvalid;
            s1_rvalid = 1'b0;
            m_rready  = s0_rready;
        end
    end

endmodule

// File: tb/tb_axi4_burst_arbiter.sv
// Directed self-checking bench for axi4_burst_arbiter.
module tb_axi4_burst_arbiter;

    localparam int C_ID_LEN   = 8;
    localparam int C_DATA_LEN = 128;
    localparam int C_STRB_LEN = 16;

    logic axi_clk = 1'b0;
    logic axi_reset;

    logic [31:0] s0_awaddr, s1_awaddr, s0_araddr, s1_araddr;
    logic [7:0]  s0_awlen, s1_awlen, s0_arlen, s1_arlen;
    logic s0_awvalid, s1_awvalid, s0_awready, s1_awready;
    logic [C_DATA_LEN-1:0] s0_wdata, s1_wdata, s0_rdata, s1_rdata;
    logic [C_STRB_LEN-1:0] s0_wstrb, s1_wstrb;
    logic s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
    logic [1:0] s0_bresp, s1_bresp, s0_rresp, s1_rresp;
    logic s0_bvalid, s1_bvalid;
    logic s0_arvalid, s1_arvalid, s0_arready, s1_arready;
    logic s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;
    logic [C_ID_LEN-1:0] m_awid, m_bid, m_arid, m_rid;
    logic [31:0] m_awaddr, m_araddr;
    logic [7:0]  m_awlen, m_arlen;
    logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic [C_DATA_LEN-1:0] m_wdata, m_rdata;
    logic [C_STRB_LEN-1:0] m_wstrb;
    logic [1:0] m_bresp, m_rresp;
    logic m_bvalid, m_bready, m_arvalid, m_arready;
    logic m_rlast, m_rvalid, m_rready;
    logic [2:0] wr_out_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_ok;

    axi4_burst_arbiter #(
        .C_ID_LEN   (C_ID_LEN),
        .C_DATA_LEN (C_DATA_LEN),
        .C_STRB_LEN (C_STRB_LEN),
        .C_WR_OUT   (4)
    ) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset),
        .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
        .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid),
        .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid),
        .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .wr_out_cnt(wr_out_cnt)
    );

    // 100 MHz clock.
    always #5 axi_clk = ~axi_clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    // Safety net against a stuck run.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_reset = 1'b1;
        s0_awaddr = 32'h0; s0_awlen = 8'h0; s0_awvalid = 1'b0;
        s1_awaddr = 32'h0; s1_awlen = 8'h0; s1_awvalid = 1'b0;
        s0_wdata = '0; s0_wstrb = {C_STRB_LEN{1'b1}}; s0_wlast = 1'b0; s0_wvalid = 1'b0;
        s1_wdata = '0; s1_wstrb = {C_STRB_LEN{1'b1}}; s1_wlast = 1'b0; s1_wvalid = 1'b0;
        s0_araddr = 32'h0; s0_arlen = 8'h0; s0_arvalid = 1'b0; s0_rready = 1'b1;
        s1_araddr = 32'h0; s1_arlen = 8'h0; s1_arvalid = 1'b0; s1_rready = 1'b1;
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_bid = 8'h0; m_bresp = 2'b00; m_bvalid = 1'b0;
        m_rid = 8'h0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0; m_rvalid = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        chk("rst_m_awvalid", m_awvalid, 1'b0);
        chk("rst_m_arvalid", m_arvalid, 1'b0);
        chk("rst_m_wvalid", m_wvalid, 1'b0);
        chk("rst_s0_wready", s0_wready, 1'b0);
        chk("rst_wr_out_cnt", wr_out_cnt, 3'd0);
        axi_reset = 1'b0;
        tick();

        // ---- single s0 write burst, 128 beats ----
        m_awready = 1'b1; m_wready = 1'b1;
        s0_awaddr = 32'h0000_1000; s0_awlen = 8'd127; s0_awvalid = 1'b1;
        #1;
        chk("t1_awvalid_not_same_cycle", m_awvalid, 1'b0);
        tick();
        chk("t1_m_awvalid", m_awvalid, 1'b1);
        chk("t1_m_awid", m_awid, 8'h00);
        chk("t1_m_awaddr", m_awaddr, 32'h0000_1000);
        chk("t1_m_awlen", m_awlen, 8'd127);
        chk("t1_rdy", {s0_awready, s1_awready}, 2'b10);
        tick();
        s0_awvalid = 1'b0;
        #1;
        chk("t1_cnt_after_aw", wr_out_cnt, 3'd1);
        cnt_ok = 0;
        for (int i = 0; i < 128; i++) begin
            s0_wvalid = 1'b1; s0_wdata = 128'(i + 32'h100); s0_wlast = (i == 127);
            #1;
            if (m_wvalid && s0_wready && !s1_wready && m_wdata == 128'(i + 32'h100) && m_wlast == (i == 127))
                cnt_ok++;
            tick();
        end
        s0_wvalid = 1'b0; s0_wlast = 1'b0;
        #1;
        chk("t1_beats_fwd", cnt_ok, 128);
        chk("t1_cnt_done", wr_out_cnt, 3'd0);
        chk("t1_wvalid_idle", m_wvalid, 1'b0);
        m_bvalid = 1'b1; m_bid = 8'h02; m_bresp = 2'b01;
        #1;
        chk("b_to_s0", {s1_bvalid, s0_bvalid, s0_bresp}, 4'b0101);
        chk("b_bready", m_bready, 1'b1);
        m_bid = 8'h03; m_bresp = 2'b10;
        #1;
        chk("b_to_s1", {s1_bvalid, s0_bvalid, s1_bresp}, 4'b1010);
        m_bvalid = 1'b0;
        tick();

        // ---- reset at beat 40 of a write burst ----
        s0_awaddr = 32'h0000_8000; s0_awlen = 8'd127; s0_awvalid = 1'b1;
        tick();
        tick();
        s0_awvalid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            s0_wvalid = 1'b1; s0_wdata = 128'(i); s0_wlast = 1'b0;
            tick();
        end
        s0_wdata = 128'(40);
        #1;
        chk("rst40_pre_wvalid", m_wvalid, 1'b1);
        axi_reset = 1'b1;
        s0_awaddr = 32'h0000_2000; s0_awlen = 8'd0; s0_awvalid = 1'b1;
        s1_awaddr = 32'h0000_3000; s1_awlen = 8'd0; s1_awvalid = 1'b1;
        #1;
        chk("rst40_m_wvalid", m_wvalid, 1'b0);
        chk("rst40_s_wready", {s0_wready, s1_wready}, 2'b00);
        chk("rst40_cnt", wr_out_cnt, 3'd0);
        chk("rst40_aw", {m_awvalid, s0_awready, s1_awready}, 3'b000);
        tick();
        axi_reset = 1'b0; s0_wvalid = 1'b0;

        // ---- both AW after reset: s0 first, then s1; W in AW order ----
        tick();
        chk("t2_first_awid", m_awid, 8'h00);
        chk("t2_first_addr", m_awaddr, 32'h0000_2000);
        chk("t2_first_rdy", {s0_awready, s1_awready}, 2'b10);
        tick();
        s0_awvalid = 1'b0;
        #1;
        chk("t2_gap", m_awvalid, 1'b0);
        tick();
        chk("t2_second_awid", m_awid, 8'h01);
        chk("t2_second_addr", m_awaddr, 32'h0000_3000);
        chk("t2_second_rdy", {s0_awready, s1_awready}, 2'b01);
        tick();
        s1_awvalid = 1'b0;
        s0_wvalid = 1'b1; s0_wlast = 1'b1; s0_wdata = 128'hA0;
        s1_wvalid = 1'b1; s1_wlast = 1'b1; s1_wdata = 128'hB0;
        #1;
        chk("t2_cnt", wr_out_cnt, 3'd2);
        chk("t2_w0_data", m_wdata, 128'hA0);
        chk("t2_w0_rdy", {s0_wready, s1_wready}, 2'b10);
        tick();
        s0_wvalid = 1'b0;
        #1;
        chk("t2_w1_data", m_wdata, 128'hB0);
        chk("t2_w1_rdy", {s0_wready, s1_wready}, 2'b01);
        tick();
        s1_wvalid = 1'b0;
        #1;
        chk("t2_cnt_done", wr_out_cnt, 3'd0);

        // ---- simultaneous push and pop at occupancy 2 ----
        m_wready = 1'b0;
        s1_awaddr = 32'h0000_4000; s1_awvalid = 1'b1;
        tick();
        tick();
        s1_awvalid = 1'b0;
        s0_awaddr = 32'h0000_5000; s0_awvalid = 1'b1;
        tick();
        tick();
        s0_awvalid = 1'b0;
        #1;
        chk("pp_cnt_before", wr_out_cnt, 3'd2);
        s1_awaddr = 32'h0000_6000; s1_awvalid = 1'b1;
        tick();
        m_wready = 1'b1; s1_wvalid = 1'b1; s1_wlast = 1'b1; s1_wdata = 128'hC1;
        #1;
        chk("pp_aw_and_w", {m_awvalid, m_wvalid, m_wdata[7:0]}, {2'b11, 8'hC1});
        tick();
        s1_awvalid = 1'b0; s1_wvalid = 1'b0;
        #1;
        chk("pp_cnt_same", wr_out_cnt, 3'd2);
        s0_wvalid = 1'b1; s0_wlast = 1'b1; s0_wdata = 128'hC2;
        #1;
        chk("pp_head_s0", {s0_wready, s1_wready, m_wdata[7:0]}, {2'b10, 8'hC2});
        tick();
        s0_wvalid = 1'b0;
        s1_wvalid = 1'b1; s1_wdata = 128'hC3;
        #1;
        chk("pp_head_s1", {s0_wready, s1_wready, m_wdata[7:0]}, {2'b01, 8'hC3});
        tick();
        s1_wvalid = 1'b0;
        #1;
        chk("pp_cnt_done", wr_out_cnt, 3'd0);

        // ---- FIFO full: five AWs with W stalled ----
        m_wready = 1'b0;
        s0_awaddr = 32'h0000_7000; s0_awlen = 8'd0; s0_awvalid = 1'b1;
        cnt_ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (m_awvalid && m_awready) cnt_ok++;
            tick();
        end
        chk("full_hs_count", cnt_ok, 4);
        chk("full_cnt", wr_out_cnt, 3'd4);
        chk("full_stall", {m_awvalid, s0_awready}, 2'b00);
        m_wready = 1'b1; s0_wvalid = 1'b1; s0_wlast = 1'b1; s0_wdata = 128'hF0;
        #1;
        chk("full_pop_w", m_wvalid, 1'b1);
        tick();
        m_wready = 1'b0; s0_wvalid = 1'b0;
        #1;
        chk("full_cnt_pop", wr_out_cnt, 3'd3);
        chk("full_no_aw_yet", m_awvalid, 1'b0);
        tick();
        chk("full_fifth_aw", m_awvalid, 1'b1);
        tick();
        s0_awvalid = 1'b0;
        #1;
        chk("full_cnt_refill", wr_out_cnt, 3'd4);
        m_wready = 1'b1; s0_wvalid = 1'b1;
        repeat (4) tick();
        s0_wvalid = 1'b0; s0_wlast = 1'b0; m_wready = 1'b0;
        #1;
        chk("full_drain", wr_out_cnt, 3'd0);

        // ---- AR round robin with both requesters continuous ----
        m_arready = 1'b1;
        s0_araddr = 32'h0000_0100; s0_arlen = 8'd3; s0_arvalid = 1'b1;
        s1_araddr = 32'h0000_0200; s1_arlen = 8'd3; s1_arvalid = 1'b1;
        tick();
        chk("ar_g0", {m_arvalid, m_arid, s0_arready, s1_arready}, {1'b1, 8'h00, 2'b10});
        chk("ar_g0_addr", m_araddr, 32'h0000_0100);
        tick();
        tick();
        chk("ar_g1", {m_arvalid, m_arid, s0_arready, s1_arready}, {1'b1, 8'h01, 2'b01});
        chk("ar_g1_addr", m_araddr, 32'h0000_0200);
        tick();
        tick();
        chk("ar_g2", {m_arvalid, m_arid}, {1'b1, 8'h00});
        tick();
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;

        // ---- R interleaved per beat ----
        cnt_ok = 0;
        for (int n = 0; n < 8; n++) begin
            m_rvalid = 1'b1;
            m_rid = 8'(n % 2);
            m_rdata = (n % 2 == 1) ? 128'(32'h200 + n / 2) : 128'(32'h100 + n / 2);
            m_rlast = (n / 2 == 3);
            #1;
            if (n % 2 == 0) begin
                if (s0_rvalid && !s1_rvalid && m_rready && s0_rdata == 128'(32'h100 + n / 2)) cnt_ok++;
            end else begin
                if (s1_rvalid && !s0_rvalid && m_rready && s1_rdata == 128'(32'h200 + n / 2)) cnt_ok++;
            end
            tick();
        end
        chk("r_interleave", cnt_ok, 8);
        s1_rready = 1'b0;
        m_rid = 8'h01; m_rresp = 2'b11;
        #1;
        chk("r_s1_stall", {m_rready, s1_rvalid, s0_rvalid, s1_rresp}, 5'b01011);
        m_rid = 8'h00;
        #1;
        chk("r_s0_flows", {m_rready, s0_rvalid, s1_rvalid}, 3'b110);
        m_rvalid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_burst_arbiter.md
Name: axi4_burst_arbiter

Overview:
- Shares one AXI4 slave port (DDR controller) between two frame-buffer masters, e.g. camera-path and display-path AXI frame controllers.
- Arbitrates AW and AR round-robin, burst-granular.
- Routes W by an in-order grant FIFO.
- Routes B and R back by ID bit 0.
- Sits between the frame controllers and the DDR AXI port; all logic in axi_clk.

Parameters:
- C_ID_LEN, 8, AXI ID width; bit 0 of master-side IDs carries the requester index.
- C_DATA_LEN, 128, AXI data width.
- C_STRB_LEN, C_DATA_LEN/8, strobe width.
- C_WR_OUT, 4, write-order FIFO depth, i.e. the maximum number of AW-accepted bursts whose W is not yet complete; power of 2.

Ports:
- axi_clk  in  1  clock
- axi_reset  in  1  asynchronous, active-high reset
- s{0,1}_awaddr  in  32  per-requester write address
- s{0,1}_awlen  in  8  burst length-1
- s{0,1}_awvalid / s{0,1}_awready  in / out  1  AW handshake
- s{0,1}_wdata, s{0,1}_wstrb, s{0,1}_wlast  in  C_DATA_LEN / C_STRB_LEN / 1  write data
- s{0,1}_wvalid / s{0,1}_wready  in / out  1  W handshake
- s{0,1}_bresp / s{0,1}_bvalid  out  2 / 1  write response
- s{0,1}_araddr, s{0,1}_arlen  in  32 / 8  read address
- s{0,1}_arvalid / s{0,1}_arready  in / out  1  AR handshake
- s{0,1}_rdata, s{0,1}_rresp, s{0,1}_rlast, s{0,1}_rvalid  out  C_DATA_LEN / 2 / 1 / 1  read data
- s{0,1}_rready  in  1
- m_awid, m_awaddr, m_awlen  out  C_ID_LEN / 32 / 8  to DDR
- m_awvalid / m_awready  out / in  1
- m_wdata, m_wstrb, m_wlast, m_wvalid  out  C_DATA_LEN / C_STRB_LEN / 1 / 1
- m_wready  in  1
- m_bid, m_bresp, m_bvalid  in  C_ID_LEN / 2 / 1
- m_bready  out  1
- m_arid, m_araddr, m_arlen, m_arvalid  out  C_ID_LEN / 32 / 8 / 1
- m_arready  in  1
- m_rid, m_rdata, m_rresp, m_rlast, m_rvalid  in  C_ID_LEN / C_DATA_LEN / 2 / 1 / 1
- m_rready  out  1
- wr_out_cnt  out  log2(C_WR_OUT)+1  write-order FIFO occupancy (debug)

Behaviour:
- Reset (asynchronous, axi_reset high):
  - All m_*valid, s_*ready and s_*valid are 0.
  - Both round-robin pointers = 0 (requester 0 has priority first).
  - Write-order FIFO empty; wr_out_cnt = 0.
  - AW and AR FSMs in IDLE.
  - Reset mid-burst abandons the burst; the DDR side is reset alongside.
- AW FSM, IDLE -> GRANT:
  - In IDLE, if any s_awvalid is set and the FIFO is not full, register grant g.
  - If both are valid, g = rr pointer; otherwise g = the single valid requester.
- AW FSM, in GRANT:
  - m_aw* = s{g}_aw*; m_awid = {zeros, g}; s{g}_awready = m_awready; the other requester's awready = 0.
  - On m_awvalid & m_awready: push g into the FIFO, rr pointer = ~g, return to IDLE.
- AW timing:
  - Minimum 1 cycle from s_awvalid to m_awvalid; 2 cycles per AW grant.
  - Requesters must hold valid until ready.
- W routing:
  - When the FIFO is non-empty, h = head: m_w* = s{h}_w*; s{h}_wready = m_wready; the other requester's wready = 0.
  - When the FIFO is empty: m_wvalid = 0 and all s_wready = 0.
  - Pop on m_wvalid & m_wready & m_wlast.
  - Simultaneous push and pop leaves occupancy unchanged.
  - W for a burst starts no earlier than the cycle after its AW handshake.
- FIFO full: no new AW grant is issued; a grant already in GRANT still completes (full is checked only in IDLE).
- B path:
  - s{m_bid[0]}_bvalid = m_bvalid and bresp is passed through; the other requester's bvalid = 0.
  - m_bready = 1 (requesters tie bready high).
- AR FSM: same structure as AW with an independent rr pointer; no FIFO limit; m_arid = {zeros, g}.
- R path:
  - k = m_rid[0]; s{k}_rvalid = m_rvalid; s{k}_r* = m_r*; m_rready = s{k}_rready.
  - Interleaving is tolerated because routing is per beat.
- Combinational paths: only the ready/valid pass-throughs; grant selection is registered.

Decomposition:
- Package axi_arb_pkg: C_REQ_NUM = 2, an FSM state enum (IDLE, GRANT), and an ID-index extract helper.
- Sub-module axi_arb_rr2: the 2-way round-robin AW/AR grant FSM, instantiated twice.
- The write-order FIFO is inline (register array plus pointers).

Test Plan:
- Only s0_awvalid, awlen = 127, 128 W beats, m_awready = m_wready = 1: m_awvalid rises 1 cycle after the request, m_awid = 0, all 128 beats forwarded, B routed to s0 only.
- s0 and s1 AW valid in the same cycle after reset: s0 granted first (m_awid[0] = 0), then s1 (m_awid[0] = 1); W bursts follow in AW order.
- m_wready held 0 while 5 AW requests issue with C_WR_OUT = 4: exactly 4 AW handshakes, wr_out_cnt = 4, fifth AW stalls until the first wlast pops.
- Both AR requesters continuous; DDR returns R with rid[0] alternating per beat: each requester's rdata matches its own addresses; s1_rready = 0 stalls only rid[0] = 1 beats.
- Reset asserted at beat 40 of a write burst: all valid/ready go 0 immediately; wr_out_cnt = 0; next AW after release is granted to s0.
- Simultaneous AW handshake and wlast pop at occupancy 2: occupancy stays 2; head advances correctly.
